// File: rtl/knn_result_packer.sv
// knn_result_packer
// Buffers the KNN accelerator's result strobes in a small FIFO and ships each
// result as two AXI4-Stream beats toward the DMA: name, then value. TLAST marks
// the value beat of the K-th result of every query.
// Build option KNN_QUERY_HEADER_EN: each packet is prefixed with a header beat
// 32'hA5A5_0000 | query_counter, where the counter advances on each TLAST.
module knn_result_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        mclk,
  input  logic                        reset,
  input  logic                        res_wr_en,
  input  logic [31:0]                 res_name,
  input  logic [DATA_WIDTH-1:0]       res_value,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [31:0]                 m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [RCW-1:0] LAST_IDX   = RCW'(K - 1);
`ifdef KNN_QUERY_HEADER_EN
  localparam logic [31:0]    HDR_TAG    = 32'hA5A5_0000;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NAME  = 2'd1,
    VALUE = 2'd2
`ifdef KNN_QUERY_HEADER_EN
    , HDR = 2'd3
`endif
  } state_t;

  // Result storage: small array with combinational head read so the head entry
  // is usable in the same cycle the pointer moves (no stale-read hazard when a
  // push lands right behind a pop).
  logic [31:0]           name_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] value_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  not_empty_d_reg;

  state_t                state_reg, state_next;
  logic                  tvalid_reg, tvalid_next;
  logic [31:0]           tdata_reg, tdata_next;
  logic                  tlast_reg, tlast_next;
  logic [RCW-1:0]        res_cnt_reg, res_cnt_next;
`ifdef KNN_QUERY_HEADER_EN
  logic [15:0]           qcnt_reg, qcnt_next;
`endif

  logic                  fifo_full, fifo_nonempty, push, pop, hs;
  logic [31:0]           head_name;
  logic [DATA_WIDTH-1:0] head_value;

  // Fullness is judged on the registered count, so a push while full is
  // dropped even when a pop happens in the same cycle.
  assign fifo_full     = (count_reg == FULL_COUNT);
  assign fifo_nonempty = (count_reg != '0);
  assign push          = res_wr_en & ~fifo_full;
  assign hs            = tvalid_reg & m_axis_tready;
  assign head_name     = name_mem[rd_ptr_reg];
  assign head_value    = value_mem[rd_ptr_reg];

  // Storage array write (no reset needed on the data itself).
  always_ff @(posedge mclk) begin
    if (push) begin
      name_mem[wr_ptr_reg]  <= res_name;
      value_mem[wr_ptr_reg] <= res_value;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      not_empty_d_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (res_wr_en && fifo_full) overflow_reg <= 1'b1;
      // Delayed non-empty view paces packet start: tvalid rises two edges
      // after the push that filled an empty FIFO.
      not_empty_d_reg <= fifo_nonempty;
    end
  end

  // Output FSM state and registered AXIS outputs.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tvalid_reg  <= 1'b0;
      tdata_reg   <= '0;
      tlast_reg   <= 1'b0;
      res_cnt_reg <= '0;
`ifdef KNN_QUERY_HEADER_EN
      qcnt_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      tvalid_reg  <= tvalid_next;
      tdata_reg   <= tdata_next;
      tlast_reg   <= tlast_next;
      res_cnt_reg <= res_cnt_next;
`ifdef KNN_QUERY_HEADER_EN
      qcnt_reg    <= qcnt_next;
`endif
    end
  end

  // Next-state and next-beat selection; outputs hold unless a handshake
  // (or packet start from IDLE) moves the stream forward.
  always_comb begin
    state_next   = state_reg;
    tvalid_next  = tvalid_reg;
    tdata_next   = tdata_reg;
    tlast_next   = tlast_reg;
    res_cnt_next = res_cnt_reg;
`ifdef KNN_QUERY_HEADER_EN
    qcnt_next    = qcnt_reg;
`endif
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (not_empty_d_reg && fifo_nonempty) begin
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
          state_next  = NAME;
          tdata_next  = head_name;
`ifdef KNN_QUERY_HEADER_EN
          if (res_cnt_reg == '0) begin
            state_next = HDR;
            tdata_next = HDR_TAG | {16'h0000, qcnt_reg};
          end
`endif
        end
      end
`ifdef KNN_QUERY_HEADER_EN
      HDR: begin
        if (hs) begin
          state_next = NAME;
          tdata_next = head_name;
          tlast_next = 1'b0;
        end
      end
`endif
      NAME: begin
        if (hs) begin
          pop        = 1'b1;
          tdata_next = 32'(head_value);
          tlast_next = (res_cnt_reg == LAST_IDX);
          state_next = VALUE;
        end
      end
      VALUE: begin
        if (hs) begin
          res_cnt_next = tlast_reg ? '0 : res_cnt_reg + RCW'(1);
`ifdef KNN_QUERY_HEADER_EN
          if (tlast_reg) qcnt_next = qcnt_reg + 16'd1;
`endif
          if (fifo_nonempty) begin
            // Back-to-back results: next name beat follows without a bubble.
            state_next = NAME;
            tdata_next = head_name;
            tlast_next = 1'b0;
`ifdef KNN_QUERY_HEADER_EN
            if (tlast_reg) begin
              state_next = HDR;
              tdata_next = HDR_TAG | {16'h0000, qcnt_next};
            end
`endif
          end else begin
            state_next  = IDLE;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
            tdata_next  = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tlast  = tlast_reg;
  assign overflow      = overflow_reg;
  assign fifo_count    = count_reg;

endmodule

// File: tb/tb_knn_result_packer.sv
// tb_knn_result_packer
// Three packers (K = 1, 2, 3; FIFO_DEPTH = 4; 16-bit values) share one result
// stream and one tready. Each lane keeps an expected-beat queue derived from
// the accepted results and compares every handshake, occupancy, overflow and
// hold-stability on every cycle; directed sections pin literal beat sequences.
// Honours KNN_QUERY_HEADER_EN the same way as the design.
`timescale 1ns/1ps
module tb_knn_result_packer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NL    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef KNN_QUERY_HEADER_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    bit          is_name;
  } beat_t;

  logic          mclk = 1'b0;
  logic          reset = 1'b0;
  logic          res_wr_en = 1'b0;
  logic          tready = 1'b0;
  logic [31:0]   res_name = '0;
  logic [DW-1:0] res_value = '0;

  logic [NL-1:0] l_tvalid, l_tlast, l_ovf;
  logic [31:0]   l_tdata [NL];
  logic [CW-1:0] l_cnt   [NL];
  int            l_qsize [NL];

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One lane per K value, each with its own reference queue.
  for (genvar gi = 0; gi < NL; gi++) begin : lane
    localparam int KL = gi + 1;

    knn_result_packer #(.DATA_WIDTH(DW), .K(KL), .FIFO_DEPTH(DEPTH)) dut (
      .mclk          (mclk),
      .reset         (reset),
      .res_wr_en     (res_wr_en),
      .res_name      (res_name),
      .res_value     (res_value),
      .m_axis_tvalid (l_tvalid[gi]),
      .m_axis_tready (tready),
      .m_axis_tdata  (l_tdata[gi]),
      .m_axis_tlast  (l_tlast[gi]),
      .overflow      (l_ovf[gi]),
      .fifo_count    (l_cnt[gi])
    );

    beat_t       exp_q[$];
    int          mcount = 0;
    int          ridx = 0;
    bit          movf = 1'b0;
    bit          known = 1'b0;
    bit          after_rst = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    // Compare current outputs, then advance the model for the coming edge.
    always @(negedge mclk) begin
      beat_t b;
      bit    pop_name;
      pop_name = 1'b0;
      if (known) begin
        chk($sformatf("lane%0d fifo_count", gi), 32'(l_cnt[gi]), 32'(mcount));
        chk($sformatf("lane%0d overflow", gi), 32'(l_ovf[gi]), 32'(movf));
        if (after_rst) begin
          chk($sformatf("lane%0d reset tvalid", gi), 32'(l_tvalid[gi]), 32'd0);
          chk($sformatf("lane%0d reset tdata", gi), l_tdata[gi], 32'd0);
          chk($sformatf("lane%0d reset tlast", gi), 32'(l_tlast[gi]), 32'd0);
        end
        if (hold) begin
          chk($sformatf("lane%0d hold tvalid", gi), 32'(l_tvalid[gi]), 32'd1);
          chk($sformatf("lane%0d hold tdata", gi), l_tdata[gi], hold_data);
          chk($sformatf("lane%0d hold tlast", gi), 32'(l_tlast[gi]), 32'(hold_last));
        end
        if (l_tvalid[gi] && tready && reset) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d spurious beat: got %h expected no beat", gi, l_tdata[gi]);
          end else begin
            b = exp_q.pop_front();
            chk($sformatf("lane%0d beat data", gi), l_tdata[gi], b.data);
            chk($sformatf("lane%0d beat last", gi), 32'(l_tlast[gi]), 32'(b.last));
            pop_name = b.is_name;
            if (verbose)
              $display("lane%0d beat data=%h last=%0d", gi, l_tdata[gi], l_tlast[gi]);
          end
        end
      end
      if (!reset) begin
        exp_q.delete();
        mcount    = 0;
        ridx      = 0;
        movf      = 1'b0;
        known     = 1'b1;
        after_rst = 1'b1;
        hold      = 1'b0;
      end else if (known) begin
        after_rst = 1'b0;
        if (res_wr_en) begin
          if (mcount == DEPTH) begin
            movf = 1'b1;
          end else begin
            if (HDR_ON && (ridx % KL == 0)) begin
              b.data    = 32'hA5A5_0000 | 32'((ridx / KL) % 65536);
              b.last    = 1'b0;
              b.is_name = 1'b0;
              exp_q.push_back(b);
            end
            b.data    = res_name;
            b.last    = 1'b0;
            b.is_name = 1'b1;
            exp_q.push_back(b);
            b.data    = 32'(res_value);
            b.last    = (ridx % KL == KL - 1);
            b.is_name = 1'b0;
            exp_q.push_back(b);
            ridx++;
            mcount++;
          end
        end
        if (pop_name) mcount--;
        hold      = l_tvalid[gi] && !tready;
        hold_data = l_tdata[gi];
        hold_last = l_tlast[gi];
      end
      l_qsize[gi] = exp_q.size();
    end
  end

  // Inputs change 2 ns after the rising edge.
  task automatic tick();
    @(posedge mclk);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    res_wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] n, input logic [DW-1:0] v);
    res_wr_en = 1'b1;
    res_name  = n;
    res_value = v;
    tick();
    res_wr_en = 1'b0;
  endtask

  // Literal expected-beat list for the directed sections.
  logic [31:0] eb_d [16];
  logic        eb_t [16];
  int          eb_n;

  task automatic eb_add(input logic [31:0] d, input logic t);
    eb_d[eb_n] = d;
    eb_t[eb_n] = t;
    eb_n++;
  endtask

  task automatic eb_result(input logic [31:0] n, input logic [31:0] v, input logic last,
                           input bit first, input int q);
    if (HDR_ON && first) eb_add(32'hA5A5_0000 | 32'(q), 1'b0);
    eb_add(n, 1'b0);
    eb_add(v, last);
  endtask

  task automatic expect_beats(input string tag, input int l, output int bubbles);
    logic [31:0] d [16];
    logic        t [16];
    int          got;
    got     = 0;
    bubbles = 0;
    for (int c = 0; c < 200 && got < eb_n; c++) begin
      @(negedge mclk);
      if (l_tvalid[l] && tready) begin
        d[got] = l_tdata[l];
        t[got] = l_tlast[l];
        got++;
      end else if (got > 0) begin
        bubbles++;
      end
    end
    checks++;
    if (got < eb_n) begin
      errors++;
      $display("FAIL %s beat count: got %0d expected %0d", tag, got, eb_n);
    end
    for (int i = 0; i < got; i++) begin
      chk($sformatf("%s beat%0d data", tag, i), d[i], eb_d[i]);
      chk($sformatf("%s beat%0d last", tag, i), 32'(t[i]), 32'(eb_t[i]));
    end
  endtask

  initial begin
    int bub;
    bit seen;

    // Basic K=1 latency and beat contents.
    do_reset();
    tready    = 1'b1;
    res_wr_en = 1'b1;
    res_name  = 32'd5;
    res_value = 16'h0064;
    @(posedge mclk);
    #2;
    res_wr_en = 1'b0;
    @(negedge mclk); chk("t1 tvalid after N", 32'(l_tvalid[0]), 32'd0);
    @(negedge mclk); chk("t1 tvalid after N+1", 32'(l_tvalid[0]), 32'd0);
    @(negedge mclk); chk("t1 tvalid after N+2", 32'(l_tvalid[0]), 32'd1);
`ifdef KNN_QUERY_HEADER_EN
    chk("t1 header", l_tdata[0], 32'hA5A5_0000);
    @(negedge mclk);
`endif
    chk("t1 name", l_tdata[0], 32'd5);
    chk("t1 name last", 32'(l_tlast[0]), 32'd0);
    @(negedge mclk);
    chk("t1 value", l_tdata[0], 32'h64);
    chk("t1 value last", 32'(l_tlast[0]), 32'd1);
    @(negedge mclk); chk("t1 idle after", 32'(l_tvalid[0]), 32'd0);

    // K=3 streaming, then a fourth result opening a new packet.
    do_reset();
    push(32'd0, 16'd10);
    push(32'd1, 16'd20);
    push(32'd2, 16'd30);
    eb_n = 0;
    eb_result(32'd0, 32'd10, 1'b0, 1'b1, 0);
    eb_result(32'd1, 32'd20, 1'b0, 1'b0, 0);
    eb_result(32'd2, 32'd30, 1'b1, 1'b0, 0);
    expect_beats("t2 k3", 2, bub);
    chk("t2 bubbles", 32'(bub), 32'd0);
    tick();
    push(32'd3, 16'd40);
    eb_n = 0;
    eb_result(32'd3, 32'd40, 1'b0, 1'b1, 1);
    expect_beats("t2 k3 second", 2, bub);

    // Backpressure during the first beat of lane K=2.
    do_reset();
    tready = 1'b0;
    push(32'd7, 16'h0077);
    push(32'd8, 16'h0088);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge mclk);
      seen = l_tvalid[1];
    end
    chk("t3 tvalid rises", 32'(seen), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge mclk);
      chk("t3 held data", l_tdata[1], HDR_ON ? 32'hA5A5_0000 : 32'd7);
      chk("t3 held last", 32'(l_tlast[1]), 32'd0);
      chk("t3 held count", 32'(l_cnt[1]), 32'd2);
    end
    tick();
    tready = 1'b1;
    eb_n = 0;
    eb_result(32'd7, 32'h77, 1'b0, 1'b1, 0);
    eb_result(32'd8, 32'h88, 1'b1, 1'b0, 0);
    expect_beats("t3 resume", 1, bub);

    // Overflow: six strobes into a 4-entry FIFO with tready low.
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'd100 + 32'(i), DW'(i * 3 + 1));
    @(negedge mclk);
    chk("t4 count full", 32'(l_cnt[0]), 32'd4);
    chk("t4 overflow", 32'(l_ovf[0]), 32'd1);
    tick();
    tready = 1'b1;
    eb_n = 0;
    for (int i = 0; i < 4; i++)
      eb_result(32'd100 + 32'(i), 32'(i * 3 + 1), 1'b1, 1'b1, i);
    expect_beats("t4 drain", 0, bub);
    repeat (3) @(negedge mclk);
    chk("t4 drained tvalid", 32'(l_tvalid[0]), 32'd0);
    chk("t4 overflow sticky", 32'(l_ovf[0]), 32'd1);

    // Reset in the middle of a K=2 packet.
    do_reset();
    tready = 1'b1;
    push(32'h11, 16'd1);
    push(32'h12, 16'd2);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge mclk);
      seen = l_tvalid[1] && (l_tdata[1] == 32'h11);
    end
    chk("t5 name beat seen", 32'(seen), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge mclk);
    chk("t5 tvalid cleared", 32'(l_tvalid[1]), 32'd0);
    chk("t5 tdata cleared", l_tdata[1], 32'd0);
    chk("t5 count cleared", 32'(l_cnt[1]), 32'd0);
    tick();
    push(32'h21, 16'd5);
    push(32'h22, 16'd6);
    eb_n = 0;
    eb_result(32'h21, 32'd5, 1'b0, 1'b1, 0);
    eb_result(32'h22, 32'd6, 1'b1, 1'b0, 0);
    expect_beats("t5 fresh", 1, bub);

`ifdef KNN_QUERY_HEADER_EN
    // Two K=1 packets with consecutive header counters.
    do_reset();
    tready = 1'b1;
    push(32'h31, 16'd7);
    push(32'h32, 16'd8);
    eb_n = 0;
    eb_add(32'hA5A5_0000, 1'b0); eb_add(32'h31, 1'b0); eb_add(32'd7, 1'b1);
    eb_add(32'hA5A5_0001, 1'b0); eb_add(32'h32, 1'b0); eb_add(32'd8, 1'b1);
    expect_beats("t6 header", 0, bub);
`endif

    // Randomized traffic, backpressure and occasional resets.
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      res_wr_en = ($urandom_range(99) < 45);
      res_name  = $urandom;
      res_value = DW'($urandom);
      tready    = ($urandom_range(99) < 70);
      reset     = ($urandom_range(399) != 0);
      tick();
    end
    reset     = 1'b1;
    res_wr_en = 1'b0;
    tready    = 1'b1;
    repeat (40) tick();
    @(negedge mclk);
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d drained queue", l), 32'(l_qsize[l]), 32'd0);
      chk($sformatf("lane%0d drained tvalid", l), 32'(l_tvalid[l]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_result_packer.md
Name: knn_result_packer

Overview:
- Consumes the KNN accelerator's result strobe (write enable, name and value) and transmits the results as an AXI4-Stream master packet toward the DMA S2MM.
- The result interface has no backpressure. Results are held in an internal FIFO, and each result is serialized as two 32-bit beats: name, then value.
- TLAST marks the value beat of the K-th result of each query.

Parameters:
- DATA_WIDTH, 32, width of result value; must be at most 32.
- K, 1, number of results per query (packet); must be at least 1.
- FIFO_DEPTH, 8, result FIFO entries; power of 2, at least 2.

Ports:
- mclk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- res_wr_en  in  1  result strobe; one result per high cycle.
- res_name  in  32  result data name/index.
- res_value  in  DATA_WIDTH  result distance value.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tdata  out  32  AXIS data.
- m_axis_tlast  out  1  end of query packet.
- overflow  out  1  sticky: a result was dropped.
- fifo_count  out  log2(FIFO_DEPTH)+1  entries currently stored.

Behaviour:
- Reset (reset==0 at a mclk edge) puts the block in this state:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - overflow=0, fifo_count=0, FIFO pointers=0.
  - result counter=0, state=IDLE.
  - Reset mid-packet abandons the packet; no TLAST is generated for it.
- FIFO write:
  - res_wr_en=1 and fifo_count<FIFO_DEPTH: store {res_name, res_value}.
  - res_wr_en=1 and full: drop the result and set overflow=1 until reset.
  - Full is judged on the registered count. A push while full is dropped even if a pop occurs in the same cycle.
- FIFO pop:
  - Occurs on the name-beat handshake.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output FSM states: IDLE, NAME, VALUE.
- IDLE:
  - If fifo_count!=0: register tdata=head name, tlast=0, tvalid=1, go to NAME.
  - Latency: push at edge N, tvalid high after edge N+2.
- NAME:
  - Hold outputs while tready=0.
  - On tvalid&tready: pop the FIFO.
  - tdata = head value, zero-extended to 32 bits.
  - tlast = (result counter == K-1).
  - Go to VALUE.
- VALUE:
  - Hold outputs while tready=0.
  - On handshake, update the result counter: if tlast, set it to 0; else increment it.
  - Then, if the post-pop FIFO is non-empty, load the next name beat (tvalid stays 1, no bubble) and go to NAME.
  - Otherwise set tvalid=0, tlast=0 and go to IDLE.
- AXIS rules:
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake.
- K=1: every value beat carries tlast=1.
- Sustained throughput: one result per 2 cycles with tready=1. A faster result burst is absorbed up to FIFO_DEPTH results.

Optional Feature:
- Macro: KNN_QUERY_HEADER_EN.
- Defined:
  - Adds state HDR and a 16-bit query counter (reset 0).
  - When a new packet starts (result counter==0 and FIFO non-empty, from IDLE or VALUE), first emit beat 32'hA5A5_0000 | query_counter with tlast=0, then go to NAME.
  - query_counter increments (wrapping at 16 bits) on each TLAST handshake.
  - HDR does not pop the FIFO.
- Not defined: no HDR state or counter; packets are name/value beats only.

Test Plan:
- Basic, K=1, tready=1: one result name=5, value=0x64 → beats 0x5 (tlast 0), 0x64 (tlast 1); tvalid first high 2 cycles after the strobe.
- K=3 streaming: 3 results, names 0,1,2 and values 10,20,30, on consecutive cycles → 6 beats 0,10,1,20,2,30, with tlast only on 30 and no tvalid bubble; a fourth result then starts a new packet.
- Backpressure: tready=0 for 5 cycles during the name beat → tdata and tlast held constant; resumes correctly; fifo_count is accurate throughout.
- Overflow, FIFO_DEPTH=4, tready=0: 6 strobes → fifo_count=4 and overflow=1. Releasing tready yields only the first 4 results in order.
- Reset mid-packet: K=2, assert reset after the first name beat → all outputs 0 the next cycle; post-reset results start a fresh packet with counter 0.
- KNN_QUERY_HEADER_EN, K=1: two results → beats A5A50000, n0, v0(tlast), A5A50001, n1, v1(tlast).
